window3x3_gen: RTL
==================

Name: window3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator for RGB444 camera pixels.
- Sits between the OV7670 capture stage (raster-order pixel stream) and the 3x3 Gaussian blur stage, which consumes its nine window outputs combinationally.
- Holds two full lines in line buffers plus a 3-column shift window, and emits one window per accepted pixel once two rows and two columns of history exist.
- Reports the window-centre coordinate for the frame-buffer write.

Parameters:
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- PIX_W, 12, pixel width (RGB444).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse before the first pixel of a frame; synchronous counter clear
- pix_in  in  PIX_W  input pixel, raster order
- pix_valid  in  1  pix_in valid this cycle; no backpressure
- win_lu, win_mu, win_ru  out  PIX_W each  top row of window (left/middle/right column)
- win_lm, win_mm, win_rm  out  PIX_W each  middle row of window
- win_ld, win_md, win_rd  out  PIX_W each  bottom row of window
- win_valid  out  1  window outputs valid
- center_x  out  $clog2(IMG_WIDTH)  column of win_mm
- center_y  out  $clog2(IMG_HEIGHT)  row of win_mm

Behaviour:
- Reset (rst_n=0, async): all window outputs, win_valid, center_x, center_y, col/row counters and shift registers go to 0. Line-buffer contents are don't-care.
- Counters col/row index the accepted pixel.
  - On an accepted pixel (pix_valid=1): col increments; at IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0.
- frame_start=1 clears col/row to 0 that cycle.
  - If pix_valid=1 in the same cycle, that pixel is accepted as (0,0); frame_start has priority over the increment.
  - A mid-frame frame_start abandons the partial frame. Line buffers are not cleared, but no window is valid until row>=2 again.
- Line buffers: LB1 holds row r-1, LB2 holds row r-2, both addressed by col. On accept at (c,r):
  - read a=LB1[c], b=LB2[c] (asynchronous read);
  - write LB2[c]<=a and LB1[c]<=pix_in.
  - Read-before-write in the same cycle; old data is used.
- Shift window: on accept, the 3x3 register array shifts one column left. The new right column is {b (u), a (m), pix_in (d)}.
  - Output names are column letter then row letter: l/m/r = cols c-2/c-1/c; u/m/d = rows r-2/r-1/r.
- Output: registered, latency 1 cycle after accept.
  - win_valid=1 iff the accepted pixel had c>=2 and r>=2; then center_x=c-1, center_y=r-1.
  - Window outputs update on every accept (valid or not).
  - win_valid is 0 on any cycle without an accept.
- Borders: centres on row 0, row IMG_HEIGHT-1, col 0 and col IMG_WIDTH-1 never produce win_valid. Downstream leaves those pixels unfiltered.
- Row wrap: stale columns from the previous line sit in the shift registers for c=0,1 of the new line. win_valid is gated off there, so they are never output as a valid window.
- Gaps: pix_valid=0 cycles freeze counters, line buffers and shift registers. Output is stream-order correct regardless of gap length.
- Throughput: one window per clock sustained.

Decomposition:
- Shared package (cam_pkg): PIX_W, IMG_WIDTH, IMG_HEIGHT, derived COL_W/ROW_W counter widths.
- Sub-module line_buffer: IMG_WIDTH x PIX_W, one write port, asynchronous read, instantiated twice. It infers distributed RAM; it may be swapped for block RAM with a pipeline re-timing in a later revision.

Test Plan:
1. Reset: hold rst_n=0 with random pix_in/pix_valid -> all outputs 0 and win_valid=0; release and send 2 lines -> win_valid stays 0.
2. Ramp frame, small params (IMG_WIDTH=8, IMG_HEIGHT=6), pix_in = row*16+col:
   - first win_valid comes one cycle after pixel (2,2), with center=(1,1), win_lu=0x000, win_mm=0x011, win_rd=0x022;
   - exactly 6*4=24 valid windows per frame.
3. Row wrap: with the same ramp, the accepts at (0,3) and (1,3) -> win_valid=0; the accept at (2,3) -> center (1,2), win_lm=0x020, win_ld=0x030.
4. Gapped input: insert 0-5 random idle cycles between pixels -> window values and centres identical to scenario 2, and win_valid never asserted on idle+1 cycles.
5. frame_start with pix_valid in the same cycle at mid-frame (row 3) -> that pixel is counted as (0,0); no win_valid until the new row 2, col 2; the second frame's windows match the golden model.
6. Async reset asserted mid-frame between clock edges -> outputs 0 immediately; after release plus frame_start, the next frame matches the golden model.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared camera-pipeline constants and pixel type.
package cam_pkg;

   localparam int unsigned PIX_W      = 12;
   localparam int unsigned IMG_WIDTH  = 640;
   localparam int unsigned IMG_HEIGHT = 480;
   localparam int unsigned COL_W      = $clog2(IMG_WIDTH);
   localparam int unsigned ROW_W      = $clog2(IMG_HEIGHT);

   typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// One-line pixel store: single write port, asynchronous read at the same address.
module line_buffer
   import cam_pkg::*;
#(
   parameter int unsigned DEPTH = cam_pkg::IMG_WIDTH
) (
   input  logic                     clk,
   input  logic                     wrEn,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  pix_t                     wrData,
   output pix_t                     rdData_c
);

   pix_t mem [DEPTH];

   // Read returns the old word during a write, giving read-before-write.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[addr] <= wrData;
      end
   end

   assign rdData_c = mem[addr];

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3-column shift window.
module window3x3_gen
   import cam_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = cam_pkg::IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT = cam_pkg::IMG_HEIGHT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          frame_start,
   input  pix_t                          pix_in,
   input  logic                          pix_valid,
   output pix_t                          win_lu,
   output pix_t                          win_mu,
   output pix_t                          win_ru,
   output pix_t                          win_lm,
   output pix_t                          win_mm,
   output pix_t                          win_rm,
   output pix_t                          win_ld,
   output pix_t                          win_md,
   output pix_t                          win_rd,
   output logic                          win_valid,
   output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
   output logic [$clog2(IMG_HEIGHT)-1:0] center_y
);

   localparam int unsigned CW = $clog2(IMG_WIDTH);
   localparam int unsigned RW = $clog2(IMG_HEIGHT);

   logic [CW-1:0] col, curCol;
   logic [RW-1:0] row, curRow;
   logic          lastCol, lastRow, winOk;
   pix_t          lb1Rd, lb2Rd;

   // Coordinate of the pixel on the input this cycle; frame_start forces (0,0).
   always_comb begin
      curCol  = frame_start ? '0 : col;
      curRow  = frame_start ? '0 : row;
      lastCol = (curCol == CW'(IMG_WIDTH - 1));
      lastRow = (curRow == RW'(IMG_HEIGHT - 1));
      winOk   = (curCol >= CW'(2)) && (curRow >= RW'(2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (pix_valid) begin
         if (lastCol) begin
            col <= '0;
            row <= lastRow ? '0 : RW'(curRow + RW'(1));
         end else begin
            col <= CW'(curCol + CW'(1));
            row <= curRow;
         end
      end else if (frame_start) begin
         col <= '0;
         row <= '0;
      end
   end

   // LB1 holds row r-1; LB2 is fed from LB1's old word so it holds row r-2.
   line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
      .clk      (clk),
      .wrEn     (pix_valid),
      .addr     (curCol),
      .wrData   (pix_in),
      .rdData_c (lb1Rd)
   );

   line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
      .clk      (clk),
      .wrEn     (pix_valid),
      .addr     (curCol),
      .wrData   (lb1Rd),
      .rdData_c (lb2Rd)
   );

   // Window registers are the outputs; valid gates off borders and stale wrap columns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_lu    <= '0;
         win_mu    <= '0;
         win_ru    <= '0;
         win_lm    <= '0;
         win_mm    <= '0;
         win_rm    <= '0;
         win_ld    <= '0;
         win_md    <= '0;
         win_rd    <= '0;
         win_valid <= 1'b0;
         center_x  <= '0;
         center_y  <= '0;
      end else begin
         win_valid <= pix_valid && winOk;
         if (pix_valid) begin
            win_lu <= win_mu;
            win_mu <= win_ru;
            win_ru <= lb2Rd;
            win_lm <= win_mm;
            win_mm <= win_rm;
            win_rm <= lb1Rd;
            win_ld <= win_md;
            win_md <= win_rd;
            win_rd <= pix_in;
         end
         if (pix_valid && winOk) begin
            center_x <= CW'(curCol - CW'(1));
            center_y <= RW'(curRow - RW'(1));
         end
      end
   end

endmodule
